param_sum_processor: RTL and testbench

//  Parametrised dedicated processor: control FSM plus register-file datapath.

---
 rtl/psp_pkg.sv | 21 ++
 rtl/param_sum_processor_if.sv | 23 ++
 rtl/psp_regfile.sv | 38 +++
 rtl/param_sum_processor.sv | 114 +++++++++++
 tb/tb_param_sum_processor.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/psp_pkg.sv
// Shared constants for the parametrised summing processor: FSM encodings,
// register-file indices and ALU operand selects.
package psp_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_ADD   = 3'd3;
  localparam logic [2:0] ST_INC   = 3'd4;
  localparam logic [2:0] ST_OUT   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam int R_ZERO = 0;
  localparam int R_I    = 1;
  localparam int R_SUM  = 2;

  // ADD_RR adds two register operands, ADD_R1 adds constant one to port A
  localparam logic ADD_RR = 1'b0;
  localparam logic ADD_R1 = 1'b1;

endpackage

// File: rtl/param_sum_processor_if.sv
// Start/busy/done handshake and result bus of the summing processor.
interface param_sum_processor_if #(
  parameter int DATA_W = 8
) ();

  logic              start;
  logic [DATA_W-1:0] limit;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [DATA_W-1:0] outport;

  modport master (
    output start, limit,
    input  busy, done, overflow, outport
  );

  modport slave (
    input  start, limit,
    output busy, done, overflow, outport
  );

endinterface

// File: rtl/psp_regfile.sv
// Register file with one write port, a dedicated init port (R1<=1, R2<=0)
// and two asynchronous read ports; R0 always reads as zero.
import psp_pkg::*;

module psp_regfile #(
  parameter int DATA_W   = 8,
  parameter int RF_DEPTH = 8,
  parameter int ADDR_W   = $clog2(RF_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeEn_i,
  input  logic [ADDR_W-1:0] writeAddr_i,
  input  logic [DATA_W-1:0] writeData_i,
  input  logic              init_i,
  input  logic [ADDR_W-1:0] readAddrA_i,
  output logic [DATA_W-1:0] readDataA_o,
  input  logic [ADDR_W-1:0] readAddrB_i,
  output logic [DATA_W-1:0] readDataB_o
);

  logic [DATA_W-1:0] mem_q [RF_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < RF_DEPTH; k++) mem_q[k] <= '0;
    end else if (init_i) begin
      mem_q[R_I]   <= DATA_W'(1);
      mem_q[R_SUM] <= '0;
    end else if (writeEn_i && (writeAddr_i != ADDR_W'(R_ZERO))) begin
      mem_q[writeAddr_i] <= writeData_i;
    end
  end

  assign readDataA_o = (readAddrA_i == ADDR_W'(R_ZERO)) ? '0 : mem_q[readAddrA_i];
  assign readDataB_o = (readAddrB_i == ADDR_W'(R_ZERO)) ? '0 : mem_q[readAddrB_i];

endmodule

// File: rtl/param_sum_processor.sv
// Dedicated processor computing 1+2+...+L: control FSM, register file,
// adder ALU and limit comparator, with overflow and wrap-safe termination.
import psp_pkg::*;

module param_sum_processor #(
  parameter int DATA_W   = 8,
  parameter int RF_DEPTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  param_sum_processor_if.slave bus
);

  localparam int ADDR_W = $clog2(RF_DEPTH);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] limit_q, limit_d;
  logic [DATA_W-1:0] outport_q, outport_d;
  logic              wrap_q, wrap_d;
  logic              overflow_q, overflow_d;

  logic              inAdd, aluSel, writeEn, initEn, loopContinue;
  logic [ADDR_W-1:0] readAddrA, writeAddr;
  logic [DATA_W-1:0] readDataA, readDataB, aluOperandB;
  logic [DATA_W:0]   aluResult;

  // Datapath steering depends only on the current state
  assign inAdd     = (state_q == ST_ADD);
  assign aluSel    = inAdd ? ADD_RR : ADD_R1;
  assign readAddrA = (inAdd || state_q == ST_OUT) ? ADDR_W'(R_SUM) : ADDR_W'(R_I);
  assign writeAddr = inAdd ? ADDR_W'(R_SUM) : ADDR_W'(R_I);
  assign writeEn   = inAdd || (state_q == ST_INC);
  assign initEn    = (state_q == ST_INIT);

  assign aluOperandB  = (aluSel == ADD_RR) ? readDataB : DATA_W'(1);
  assign aluResult    = {1'b0, readDataA} + {1'b0, aluOperandB};
  assign loopContinue = (readDataB <= limit_q) && !wrap_q;

  psp_regfile #(
    .DATA_W  (DATA_W),
    .RF_DEPTH(RF_DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .writeEn_i  (writeEn),
    .writeAddr_i(writeAddr),
    .writeData_i(aluResult[DATA_W-1:0]),
    .init_i     (initEn),
    .readAddrA_i(readAddrA),
    .readDataA_o(readDataA),
    .readAddrB_i(ADDR_W'(R_I)),
    .readDataB_o(readDataB)
  );

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    outport_d  = outport_q;
    wrap_d     = wrap_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          limit_d    = bus.limit;
          overflow_d = 1'b0;
          state_d    = ST_INIT;
        end
      end
      ST_INIT: begin
        wrap_d  = 1'b0;
        state_d = ST_CHECK;
      end
      ST_CHECK: state_d = loopContinue ? ST_ADD : ST_OUT;
      ST_ADD: begin
        if (aluResult[DATA_W]) overflow_d = 1'b1;
        state_d = ST_INC;
      end
      // A carry out of i means i passed the all-ones limit: stop the loop
      ST_INC: begin
        if (aluResult[DATA_W]) wrap_d = 1'b1;
        state_d = ST_CHECK;
      end
      ST_OUT: begin
        outport_d = readDataA;
        state_d   = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      limit_q    <= '0;
      outport_q  <= '0;
      wrap_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      outport_q  <= outport_d;
      wrap_q     <= wrap_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.overflow = overflow_q;
  assign bus.outport  = outport_q;

endmodule

// File: tb/tb_param_sum_processor.sv
// Self-checking bench for param_sum_processor: vector table of runs with a
// result scoreboard, plus hand-written mid-run start and mid-run reset cases.
module tb_param_sum_processor;

  localparam int DATA_W  = 8;
  localparam int MAX_CYC = 2000;

  typedef struct {
    logic [DATA_W-1:0] limit;
    logic [DATA_W-1:0] expOut;
    logic              expOvf;
    int                expLat;
  } vector_t;

  logic clk = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   failCount = 0;
  vector_t scoreboard[$];
  vector_t vectors[7];

  param_sum_processor_if #(.DATA_W(DATA_W)) bus ();

  param_sum_processor #(.DATA_W(DATA_W), .RF_DEPTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pulse start for one edge (edge 0) and record the expected result
  task automatic applyStimulus(input logic [DATA_W-1:0] lim, input logic [DATA_W-1:0] expOut,
                               input logic expOvf, input int expLat);
    vector_t v;
    v.limit = lim; v.expOut = expOut; v.expOvf = expOvf; v.expLat = expLat;
    scoreboard.push_back(v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.limit = lim;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy after accept", int'(bus.busy), 1);
  endtask

  // Count edges until done, optionally pulsing a stray start mid-run
  task automatic checkOutput(input string name, input bit strayStart);
    vector_t v;
    int edges = 0;
    bit seen = 1'b0;
    for (int n = 1; n <= MAX_CYC; n++) begin
      if (strayStart && n == 5) begin
        bus.start = 1'b1;
        bus.limit = 8'd3;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        edges = n;
        seen = 1'b1;
        break;
      end
    end
    v = scoreboard.pop_front();
    check({name, " done seen"}, int'(seen), 1);
    check({name, " latency"}, edges, v.expLat);
    check({name, " outport"}, int'(bus.outport), int'(v.expOut));
    check({name, " overflow"}, int'(bus.overflow), int'(v.expOvf));
    @(posedge clk); #1;
    check({name, " done one cycle"}, int'(bus.done), 0);
    check({name, " idle after done"}, int'(bus.busy), 0);
    check({name, " outport held"}, int'(bus.outport), int'(v.expOut));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.limit = '0;
    reset = 1'b1;
    vectors[0] = '{8'd10,  8'd55,  1'b0, 33};
    vectors[1] = '{8'd0,   8'd0,   1'b0, 3};
    vectors[2] = '{8'd30,  8'd209, 1'b1, 93};
    vectors[3] = '{8'd255, 8'd128, 1'b1, 768};
    vectors[4] = '{8'd1,   8'd1,   1'b0, 6};
    vectors[5] = '{8'd22,  8'd253, 1'b0, 69};
    vectors[6] = '{8'd23,  8'd20,  1'b1, 72};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset overflow", int'(bus.overflow), 0);
    check("reset outport", int'(bus.outport), 0);

    foreach (vectors[i]) begin
      applyStimulus(vectors[i].limit, vectors[i].expOut, vectors[i].expOvf, vectors[i].expLat);
      checkOutput($sformatf("vec%0d", i), 1'b0);
    end

    // Stray start mid-run is ignored; back-to-back start right after DONE
    applyStimulus(8'd10, 8'd55, 1'b0, 33);
    checkOutput("stray start", 1'b1);
    applyStimulus(8'd3, 8'd6, 1'b0, 12);
    checkOutput("after done", 1'b0);

    // Overflow set by a run, then reset during ADD of a limit=10 run
    applyStimulus(8'd30, 8'd209, 1'b1, 93);
    checkOutput("pre-reset", 1'b0);
    applyStimulus(8'd10, 8'd55, 1'b0, 33);
    void'(scoreboard.pop_front());
    @(posedge clk); #1;
    check("overflow cleared at accept", int'(bus.overflow), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset busy", int'(bus.busy), 0);
    check("midreset outport", int'(bus.outport), 0);
    check("midreset overflow", int'(bus.overflow), 0);
    begin
      int doneCount = 0;
      for (int n = 0; n < 40; n++) begin
        @(posedge clk); #1;
        if (bus.done) doneCount++;
      end
      check("midreset no done", doneCount, 0);
    end
    applyStimulus(8'd4, 8'd10, 1'b0, 15);
    checkOutput("post-reset", 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
